// File: rtl/digit_step_ctrl.sv
// digit_step_ctrl: holds a 3-bit digit that steps on prescaler ticks or debounced button presses
module digit_step_ctrl #(
  parameter int DIV       = 5_000_000,
  parameter int DB_CYCLES = 20,
  parameter int MAXV      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  input  logic       btn_step,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] b,
  output logic       tick,
  output logic       wrap
);
  localparam int PW = $clog2(DIV);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [2:0] MX = 3'(MAXV);
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] b_q, b_d;
  logic s1_q, s2_q, acc_q, acc_d, accp_q, tick_q, wrap_q, wrap_d;
  logic tick_i, btn_i, step, differ, flip, at_end;
  // prescaler: free-runs while enabled, holds its count when disabled
  always_comb begin
    tick_i = en && pre_q == PW'(DIV - 1);
    pre_d  = en ? (tick_i ? '0 : pre_q + PW'(1)) : pre_q;
  end
  // debouncer: accept a new level once the synchronised input has differed long enough
  always_comb begin
    differ = s2_q != acc_q;
    flip   = differ && cnt_q == CW'(DB_CYCLES - 1);
    acc_d  = acc_q ^ flip;
    cnt_d  = (differ && !flip) ? cnt_q + CW'(1) : '0;
    btn_i  = acc_q & ~accp_q;
  end
  // digit update: load beats step beats hold, wrapping explicitly at the range ends
  always_comb begin
    step   = tick_i | btn_i;
    at_end = dir ? b_q == MX : b_q == 3'd0;
    b_d    = load ? (load_val > MX ? MX : load_val) :
             !step ? b_q :
             at_end ? (dir ? 3'd0 : MX) :
             dir ? b_q + 3'd1 : b_q - 3'd1;
    wrap_d = !load && step && at_end;
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      acc_q  <= 1'b0;
      accp_q <= 1'b0;
      b_q    <= 3'd0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      s1_q   <= btn_step;
      s2_q   <= s1_q;
      acc_q  <= acc_d;
      accp_q <= acc_q;
      b_q    <= b_d;
      tick_q <= tick_i;
      wrap_q <= wrap_d;
    end
  end
  assign b    = b_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
endmodule
